// File: rtl/brownout_pkg.sv
// Shared types and constants for the brown-out trip-point sweep.
// BROWNOUT_SWEEP_MAJORITY_EN selects a 3-sample majority vote per code; the default is one sample.
package brownout_pkg;

  localparam int CODE_W = 3;
  localparam int NCODES = 8;
  localparam logic [CODE_W-1:0] MAX_CODE = 3'd7;

`ifdef BROWNOUT_SWEEP_MAJORITY_EN
  localparam int SAMPLE_N = 3;
`else
  localparam int SAMPLE_N = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/brownout_trip_sweep_if.sv
// vtrip/dcomp calibration bus between the sweep sequencer (slave) and its controller/analog side (master).
interface brownout_trip_sweep_if;
  import brownout_pkg::*;

  logic                start;
  logic                abort;
  logic [CODE_W-1:0]   home_code;
  logic                dcomp;
  logic [CODE_W-1:0]   vtrip;
  logic                ena_cmp;
  logic                busy;
  logic                done;
  logic [CODE_W-1:0]   level;
  logic                under;
  logic                full;
  logic [NCODES-1:0]   therm;

  modport slave (
    input  start, abort, home_code, dcomp,
    output vtrip, ena_cmp, busy, done, level, under, full, therm
  );

  modport master (
    output start, abort, home_code, dcomp,
    input  vtrip, ena_cmp, busy, done, level, under, full, therm
  );

endinterface

// File: rtl/brownout_sample_filter.sv
// Majority voter over NSAMP consecutive dcomp samples; with NSAMP=1 it degenerates to a pass-through.
module brownout_sample_filter #(
  parameter int NSAMP = 3
) (
  input  logic osc_ck,
  input  logic clr_cnt_sb,
  input  logic sample_en,
  input  logic din,
  output logic vote_valid,
  output logic vote
);

  logic [1:0] r_idx;
  logic [1:0] r_ones;
  logic [2:0] w_total;

  // Decision is made on the last sample cycle, counting the live sample too.
  assign w_total    = {1'b0, r_ones} + {2'b00, din};
  assign vote_valid = sample_en && (r_idx == 2'(NSAMP - 1));
  assign vote       = (int'(w_total) * 2) > NSAMP;

  always_ff @(posedge osc_ck or negedge clr_cnt_sb) begin
    if (!clr_cnt_sb) begin
      r_idx  <= 2'd0;
      r_ones <= 2'd0;
    end else if (!sample_en || vote_valid) begin
      r_idx  <= 2'd0;
      r_ones <= 2'd0;
    end else begin
      r_idx  <= r_idx + 2'd1;
      r_ones <= r_ones + {1'b0, din};
    end
  end

endmodule

// File: rtl/brownout_trip_sweep.sv
// Brown-out calibration sequencer: steps vtrip upward, settles, samples dcomp, reports the last passing code.
// BROWNOUT_SWEEP_MAJORITY_EN (see brownout_pkg) widens each sample window to a 3-cycle majority vote.
module brownout_trip_sweep
  import brownout_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  osc_ck,
  input  logic                  clr_cnt_sb,
  brownout_trip_sweep_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t              r_state;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   r_vtrip;
  logic [CODE_W-1:0]   r_level;
  logic [NCODES-1:0]   r_therm;
  logic                r_under;
  logic                r_full;
  logic                r_done;
  logic                r_busy;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_sample_en;
  logic                w_vote_valid;
  logic                w_vote;

  assign w_sample_en = (r_state == SAMPLE);

  brownout_sample_filter #(
    .NSAMP (SAMPLE_N)
  ) u_filter (
    .osc_ck     (osc_ck),
    .clr_cnt_sb (clr_cnt_sb),
    .sample_en  (w_sample_en),
    .din        (bus.dcomp),
    .vote_valid (w_vote_valid),
    .vote       (w_vote)
  );

  always_ff @(posedge osc_ck or negedge clr_cnt_sb) begin
    if (!clr_cnt_sb) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_vtrip <= '0;
      r_level <= '0;
      r_therm <= '0;
      r_under <= 1'b0;
      r_full  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_vtrip <= bus.home_code;
          if (bus.start) begin
            r_code  <= '0;
            r_vtrip <= '0;
            r_therm <= '0;
            r_under <= 1'b0;
            r_full  <= 1'b0;
            r_level <= '0;
            r_cnt   <= SETTLE_LOAD;
            r_busy  <= 1'b1;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            r_vtrip <= bus.home_code;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          // abort outranks any decision taken in the same cycle
          if (bus.abort) begin
            r_vtrip <= bus.home_code;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_vote_valid) begin
            if (w_vote) begin
              r_level <= (r_code == '0) ? '0 : r_code - 3'd1;
              r_under <= (r_code == '0);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_therm[r_code] <= 1'b1;
              if (r_code == MAX_CODE) begin
                r_level <= MAX_CODE;
                r_full  <= 1'b1;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= DONE;
              end else begin
                r_code  <= r_code + 3'd1;
                r_vtrip <= r_code + 3'd1;
                r_cnt   <= SETTLE_LOAD;
                r_state <= SETTLE;
              end
            end
          end
        end
        DONE: begin
          r_vtrip <= bus.home_code;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vtrip   = r_vtrip;
  assign bus.ena_cmp = r_busy;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.level   = r_level;
  assign bus.under   = r_under;
  assign bus.full    = r_full;
  assign bus.therm   = r_therm;

endmodule

// File: tb/tb_brownout_trip_sweep.sv
// Self-checking bench for brownout_trip_sweep: directed and randomized sweeps against a code-level model.
module tb_brownout_trip_sweep;

  localparam int S = 8;
`ifdef BROWNOUT_SWEEP_MAJORITY_EN
  localparam int NS = 3;
`else
  localparam int NS = 1;
`endif
  localparam int P = S + NS;

  logic osc_ck     = 1'b0;
  logic clr_cnt_sb = 1'b0;
  int   n_tests    = 0;
  int   n_fail     = 0;

  brownout_trip_sweep_if bus();

  brownout_trip_sweep #(
    .SETTLE_CYC (S),
    .CNT_W      (8)
  ) dut (
    .osc_ck     (osc_ck),
    .clr_cnt_sb (clr_cnt_sb),
    .bus        (bus)
  );

  always #5 osc_ck = ~osc_ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // comparator answer for sample k at a code; selected samples of one code can be flipped
  function automatic logic dval(input int code, input int k, input int thr,
                                input int fcode, input logic [2:0] fmask);
    logic b;
    b = (code >= thr);
    if (code == fcode) b = b ^ fmask[k];
    return b;
  endfunction

  task automatic run_sweep(input int thr, input int fcode, input logic [2:0] fmask,
                           input logic [2:0] home, input string name);
    int n, tcode, votes, code, p;
    logic trip, e_under, e_full;
    logic [7:0] e_therm;
    logic [2:0] e_level;
    n = 8; tcode = 8; trip = 1'b0;
    for (int cd = 0; cd < 8; cd++) begin
      if (!trip) begin
        votes = 0;
        for (int k = 0; k < NS; k++) votes += int'(dval(cd, k, thr, fcode, fmask));
        if (votes * 2 > NS) begin
          trip = 1'b1; tcode = cd; n = cd + 1;
        end
      end
    end
    e_therm = trip ? 8'((1 << tcode) - 1) : 8'hFF;
    e_level = trip ? ((tcode == 0) ? 3'd0 : 3'(tcode - 1)) : 3'd7;
    e_under = trip && (tcode == 0);
    e_full  = !trip;

    bus.home_code = home;
    bus.start     = 1'b1;
    bus.dcomp     = dval(0, 0, thr, -1, 3'b000);
    @(negedge osc_ck);
    bus.start = 1'b0;
    for (int c = 1; c <= n * P + 2; c++) begin
      if (c <= n * P) begin
        check({name, ".vtrip"}, 32'(bus.vtrip), 32'((c - 1) / P));
        check({name, ".busy"}, 32'(bus.busy), 32'd1);
        check({name, ".done_early"}, 32'(bus.done), 32'd0);
      end else if (c == n * P + 1) begin
        check({name, ".done"}, 32'(bus.done), 32'd1);
        check({name, ".busy_done"}, 32'(bus.busy), 32'd0);
        check({name, ".ena_done"}, 32'(bus.ena_cmp), 32'd0);
        check({name, ".vtrip_done"}, 32'(bus.vtrip), 32'(n - 1));
      end else begin
        check({name, ".done_after"}, 32'(bus.done), 32'd0);
        check({name, ".vtrip_home"}, 32'(bus.vtrip), 32'(home));
        check({name, ".level"}, 32'(bus.level), 32'(e_level));
        check({name, ".therm"}, 32'(bus.therm), 32'(e_therm));
        check({name, ".under"}, 32'(bus.under), 32'(e_under));
        check({name, ".full"}, 32'(bus.full), 32'(e_full));
      end
      code = (c - 1) / P;
      p    = (c - 1) % P;
      bus.dcomp = (p >= S) ? dval(code, p - S, thr, fcode, fmask) : (code >= thr);
      @(negedge osc_ck);
    end
    $display("[TB] sweep %s thr=%0d flip_code=%0d mask=%b -> level=%0d therm=%02h under=%0d full=%0d",
             name, thr, fcode, fmask, bus.level, bus.therm, bus.under, bus.full);
  endtask

  initial begin
    int thr, fcode;
    logic [2:0] fmask;
    bus.start = 1'b0; bus.abort = 1'b0; bus.dcomp = 1'b0; bus.home_code = 3'd5;

    // reset values
    repeat (2) @(negedge osc_ck);
    check("rst.vtrip", 32'(bus.vtrip), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.ena", 32'(bus.ena_cmp), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.therm", 32'(bus.therm), 32'd0);
    check("rst.level", 32'(bus.level), 32'd0);
    check("rst.flags", 32'({bus.under, bus.full}), 32'd0);
    clr_cnt_sb = 1'b1;
    @(negedge osc_ck);
    check("idle.vtrip_home", 32'(bus.vtrip), 32'd5);
    check("idle.busy", 32'(bus.busy), 32'd0);
    bus.home_code = 3'd2;
    @(negedge osc_ck);
    check("idle.vtrip_follow", 32'(bus.vtrip), 32'd2);
    $display("[TB] reset/idle home follow vtrip=%0d", bus.vtrip);

    run_sweep(8, -1, 3'b000, 3'd5, "full");
    run_sweep(4, -1, 3'b000, 3'd6, "trip4");
    run_sweep(0, -1, 3'b000, 3'd1, "under");
`ifdef BROWNOUT_SWEEP_MAJORITY_EN
    run_sweep(8, 1, 3'b010, 3'd3, "glitch1");
    run_sweep(8, 1, 3'b101, 3'd3, "two_of_three");
`endif

    // abort mid-SETTLE at code 2, with stray start pulses during the sweep
    bus.home_code = 3'd6; bus.dcomp = 1'b0; bus.start = 1'b1;
    @(negedge osc_ck);
    for (int c = 1; c < 2 * P + 3; c++) begin
      bus.start = (c == P + 2);
      @(negedge osc_ck);
    end
    check("abort.vtrip_pre", 32'(bus.vtrip), 32'd2);
    check("abort.busy_pre", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1; bus.start = 1'b1;
    @(negedge osc_ck);
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.ena", 32'(bus.ena_cmp), 32'd0);
    check("abort.vtrip", 32'(bus.vtrip), 32'd6);
    check("abort.therm", 32'(bus.therm), 32'h03);
    check("abort.flags", 32'({bus.under, bus.full}), 32'd0);
    bus.abort = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort.done", 32'(bus.done), 32'd0);
      @(negedge osc_ck);
    end
    check("abort.idle", 32'(bus.busy), 32'd0);
    $display("[TB] abort at code 2 therm=%02h vtrip=%0d", bus.therm, bus.vtrip);

    // start and abort together in IDLE: sweep begins, then aborts
    bus.home_code = 3'd3; bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge osc_ck);
    check("sa.busy", 32'(bus.busy), 32'd1);
    check("sa.vtrip0", 32'(bus.vtrip), 32'd0);
    check("sa.therm_clr", 32'(bus.therm), 32'd0);
    bus.start = 1'b0;
    @(negedge osc_ck);
    check("sa.busy_off", 32'(bus.busy), 32'd0);
    check("sa.vtrip_home", 32'(bus.vtrip), 32'd3);
    bus.abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("sa.done", 32'(bus.done), 32'd0);
      @(negedge osc_ck);
    end
    $display("[TB] start+abort in idle busy=%0d vtrip=%0d", bus.busy, bus.vtrip);

    // asynchronous reset mid-sweep
    bus.home_code = 3'd4; bus.start = 1'b1;
    @(negedge osc_ck);
    bus.start = 1'b0;
    repeat (2 * P + 2) @(negedge osc_ck);
    check("arst.therm_pre", 32'(bus.therm), 32'h03);
    #2 clr_cnt_sb = 1'b0;
    #1;
    check("arst.vtrip", 32'(bus.vtrip), 32'd0);
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.therm", 32'(bus.therm), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    @(negedge osc_ck);
    clr_cnt_sb = 1'b1;
    @(negedge osc_ck);
    check("arst.vtrip_home", 32'(bus.vtrip), 32'd4);
    check("arst.done_after", 32'(bus.done), 32'd0);
    $display("[TB] async reset mid-sweep vtrip=%0d therm=%02h", bus.vtrip, bus.therm);

    for (int i = 0; i < 10; i++) begin
      thr = int'($urandom_range(0, 8));
`ifdef BROWNOUT_SWEEP_MAJORITY_EN
      fcode = int'($urandom_range(0, 7));
      fmask = 3'b001 << $urandom_range(0, 2);
`else
      fcode = -1;
      fmask = 3'b000;
`endif
      run_sweep(thr, fcode, fmask, 3'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/brownout_trip_sweep.md
Name: brownout_trip_sweep

Overview:
Calibration sequencer for the brown-out comparator: it drives the vtrip code and consumes the comparator output dcomp. It steps vtrip from code 0 upward, waits a settle interval at each code, and samples dcomp. It reports the highest code at which the supply stays above the trip point, as a binary level plus a thermometer. It sits beside the brown-out digital block in the osc_ck domain and shares that block's vtrip/dcomp interface from the opposite side.

Parameters:
SETTLE_CYC, 8, osc_ck cycles spent in SETTLE at each code before sampling; legal range 1..2^CNT_W-1
CNT_W, 8, width of the settle down-counter

Ports:
osc_ck  input  1  clock, rising edge
clr_cnt_sb  input  1  reset, asynchronous, active-low
start  input  1  level-sampled sweep request; acted on only in IDLE
abort  input  1  cancels a sweep in progress; no done pulse
home_code  input  3  vtrip code restored when not sweeping
dcomp  input  1  comparator output; 1 = supply below trip at current code
vtrip  output  3  trip code to analog mux / decoder
ena_cmp  output  1  comparator enable; high while busy
busy  output  1  high in SETTLE/SAMPLE
done  output  1  one-cycle pulse at end of a completed sweep
level  output  3  highest passing code (valid from done onward; held until next start)
under  output  1  dcomp=1 already at code 0
full  output  1  all 8 codes passed
therm  output  8  bit k = 1 if code k passed

Behaviour:
- Reset (clr_cnt_sb=0, async): state=IDLE; vtrip=0, level=0, therm=0, under=0, full=0, done=0, busy=0, ena_cmp=0; settle counter=0.
- IDLE: vtrip <= home_code every cycle (1-cycle latency). If start=1: code<=0, vtrip<=0, therm/under/full/level cleared, counter<=SETTLE_CYC-1, go to SETTLE.
- SETTLE: counter decrements each cycle; counter==0 -> SAMPLE. Occupies exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle): if dcomp=1 -> level<=code-1 (if code==0: level<=0, under<=1) -> DONE. If dcomp=0 -> therm[code]<=1; if code==7 -> level<=7, full<=1 -> DONE; else code<=code+1, vtrip<=code+1, counter reload -> SETTLE.
- DONE (1 cycle): done=1, busy=0, vtrip<=home_code -> IDLE.
- Latency: with N codes examined, done is high in cycle N*(SETTLE_CYC+1)+1 after the edge that sampled start (full sweep, default: cycle 73).
- abort=1 in SETTLE/SAMPLE: next state IDLE, vtrip<=home_code, no done; level/therm/under/full keep partial values. abort has priority over SAMPLE decisions. abort in IDLE/DONE is ignored.
- start while busy is ignored; start and abort both high in IDLE -> start wins; the sweep begins and abort is re-evaluated next cycle (aborts immediately).
- Async reset mid-sweep: immediate return to reset values; no done.
- therm is always a contiguous run of ones from bit 0; under and full are mutually exclusive.
- dcomp is treated as synchronous (already retimed upstream); no internal synchroniser.

Optional Feature:
BROWNOUT_SWEEP_MAJORITY_EN
- Defined: SAMPLE lasts 3 cycles, capturing dcomp each cycle; the decision uses the 2-of-3 majority. Per-code cost becomes SETTLE_CYC+3, and the full default sweep sets done in cycle 89. abort is honoured in any SAMPLE cycle.
- Undefined: single-cycle SAMPLE as above.

Decomposition:
- brownout_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), CODE_W=3, NCODES=8, MAX_CODE=3'd7.
- One sub-module: brownout_sample_filter, a 3-sample majority voter with sample_en/vote_valid. Instantiated only under BROWNOUT_SWEEP_MAJORITY_EN; otherwise a pass-through.

Test Plan:
- Reset then idle, home_code=3'd5 -> vtrip=5 one cycle later; busy=0, done=0, therm=0.
- start pulse, dcomp tied 0 -> vtrip steps 0..7, each held 9 cycles; done in cycle 73; level=7, full=1, therm=8'hFF; vtrip returns to home_code.
- start, dcomp=1 when vtrip>=4 -> done after 5 codes (cycle 46); level=3, therm=8'h0F, under=0, full=0.
- start, dcomp=1 from the start -> done in cycle 10; under=1, level=0, therm=0.
- abort asserted at vtrip=2 mid-SETTLE -> IDLE next cycle, no done, therm=8'h03, vtrip=home_code; a second start in the same sweep ignored.
- (MAJORITY_EN) dcomp glitches 1 for one SAMPLE cycle at code 1 -> still passes (therm[1]=1); with 2 of 3 high -> level=0.
